// File: rtl/sample_loader_if.sv
// sample_loader_if -- handshake and RAM write-port bundle for sample_loader.
// The slave modport is the loader's view; the master modport is the view of
// whatever feeds samples in and consumes the RAM writes.
interface sample_loader_if #(
    parameter int BITS_PER_ROW = 3,
    parameter int DATA_W       = 16
);
    logic                    start;
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    in_ready;
    logic                    wr_en;
    logic [BITS_PER_ROW-1:0] wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_bank;
    logic                    busy;
    logic                    done;

    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output wr_bank,
        output busy,
        output done
    );

    modport master (
        output start,
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  wr_bank,
        input  busy,
        input  done
    );
endinterface

// File: rtl/sample_loader.sv
// sample_loader -- accepts one frame of N natural-order samples and writes
// them to a ping-pong RAM bank at bit-reversed addresses, ready for an
// in-place radix-2 transform.
//
// Optional feature macro: SAMPLE_LOADER_AUTO_RESTART_EN
//   defined   : after FLUSH the loader re-enters LOAD on the toggled bank
//               without waiting for another start (one bubble cycle).
//   undefined : after FLUSH the loader returns to IDLE; each frame needs start.
module sample_loader #(
    parameter int N            = 8,
    parameter int BITS_PER_ROW = 3,
    parameter int DATA_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    sample_loader_if.slave  bus
);

    localparam int                CNT_W  = BITS_PER_ROW + 1;
    localparam logic [CNT_W-1:0]  N_CNT  = CNT_W'(N);
    localparam logic [CNT_W-1:0]  N_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Reverse the bit order of an address: bit 0 becomes the MSB.
    function automatic logic [BITS_PER_ROW-1:0] bit_rev(
        input logic [BITS_PER_ROW-1:0] v
    );
        logic [BITS_PER_ROW-1:0] r;
        r = '0;
        for (int i = 0; i < BITS_PER_ROW; i++) begin
            r[i] = v[BITS_PER_ROW-1-i];
        end
        return r;
    endfunction

    state_t                  state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    wr_en_q,   wr_en_d;
    logic [BITS_PER_ROW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic                    busy_q,    busy_d;
    logic                    done_q,    done_d;

    logic                    in_ready_s;
    logic                    accept_s;

    // Ready depends only on state and count so the source may wait on it.
    always_comb begin
        in_ready_s = (state_q == S_LOAD) && (cnt_q < N_CNT);
        accept_s   = in_ready_s && bus.in_valid;
    end

    // Next-state, counter, bank and write-port computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_bank_d = wr_bank_q;
        done_d    = 1'b0;
        wr_en_d   = accept_s;

        // Write port registers the accepted sample; it holds otherwise.
        if (accept_s) begin
            wr_addr_d = bit_rev(cnt_q[BITS_PER_ROW-1:0]);
            wr_data_d = bus.in_data;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // start is deliberately not looked at here: a second request
                // mid-frame must not disturb the count or the bank.
                if (accept_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == N_LAST) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FLUSH: begin
                // The final write is on the port this cycle; completion and
                // the bank flip become visible together on the next cycle.
                done_d    = 1'b1;
                wr_bank_d = ~wr_bank_q;
`ifdef SAMPLE_LOADER_AUTO_RESTART_EN
                state_d   = S_LOAD;
                cnt_d     = '0;
`else
                state_d   = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == S_LOAD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_bank_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_bank_q <= wr_bank_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_bank  = wr_bank_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_sample_loader.sv
// tb_sample_loader -- directed test of sample_loader with N=8, DATA_W=16.
// A negedge monitor logs every RAM write and done pulse; each test task
// drives a scenario and compares the log against hand-derived values.
module tb_sample_loader;

    logic clk;
    logic rst;

    sample_loader_if #(.BITS_PER_ROW(3), .DATA_W(16)) bus ();

    sample_loader #(.N(8), .BITS_PER_ROW(3), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [2:0]  log_addr [0:63];
    logic [15:0] log_data [0:63];
    logic        log_bank [0:63];
    int          log_cyc  [0:63];
    int          log_n    = 0;
    int          done_n   = 0;
    int          done_cyc = 0;
    int          last_acc = 0;

    // Bit-reversed write order for a 3-bit address, natural sample index.
    logic [2:0] exp_addr [0:7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time writes and done pulses.
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: log writes and done pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1 && log_n < 64) begin
            log_addr[log_n] = bus.wr_addr;
            log_data[log_n] = bus.wr_data;
            log_bank[log_n] = bus.wr_bank;
            log_cyc[log_n]  = cyc;
            log_n           = log_n + 1;
        end
        if (bus.done === 1'b1) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic clear_log();
        log_n  = 0;
        done_n = 0;
    endtask

    // Drive nsamp samples base+i; gap_mask[i] inserts 3 idle cycles before
    // sample i; start is held high while sample start_at is offered.
    task automatic drive_frame(input logic [15:0] base, input logic [7:0] gap_mask,
                               input int start_at, input int nsamp);
        bit got;
        for (int i = 0; i < nsamp; i++) begin
            if (gap_mask[i]) begin
                bus.in_valid = 1'b0;
                repeat (3) step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = base + 16'(i);
            bus.start    = (i == start_at);
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (bus.in_ready === 1'b1) begin
                    got      = 1'b1;
                    last_acc = cyc;
                end
                step();
            end
            bus.start = 1'b0;
            checks++;
            if (!got) begin
                $display("FAIL accept_timeout: sample %0d in_ready=0 for 20 cycles, required 1", i);
                errors++;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        repeat (3) step();
        checks += 7;
        if (bus.in_ready !== 1'b0) begin $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); errors++; end
        if (bus.wr_en !== 1'b0)    begin $display("FAIL rst_wr_en: got %b, required 0", bus.wr_en); errors++; end
        if (bus.wr_addr !== 3'd0)  begin $display("FAIL rst_wr_addr: got %0d, required 0", bus.wr_addr); errors++; end
        if (bus.wr_data !== 16'h0) begin $display("FAIL rst_wr_data: got %0h, required 0", bus.wr_data); errors++; end
        if (bus.wr_bank !== 1'b0)  begin $display("FAIL rst_wr_bank: got %b, required 0", bus.wr_bank); errors++; end
        if (bus.busy !== 1'b0)     begin $display("FAIL rst_busy: got %b, required 0", bus.busy); errors++; end
        if (bus.done !== 1'b0)     begin $display("FAIL rst_done: got %b, required 0", bus.done); errors++; end
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0) begin $display("FAIL rst_over_start: busy got %b, required 0", bus.busy); errors++; end
        // in_valid in IDLE must be ignored
        clear_log();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hdead;
        repeat (3) step();
        @(negedge clk);
        checks += 2;
        if (bus.in_ready !== 1'b0) begin $display("FAIL idle_in_ready: got %b, required 0", bus.in_ready); errors++; end
        if (log_n !== 0)           begin $display("FAIL idle_writes: got %0d writes, required 0", log_n); errors++; end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1) begin $display("FAIL basic_busy: got %b, required 1", bus.busy); errors++; end
        drive_frame(16'h0000, 8'h00, -1, 8);
        // now in FLUSH: final write on the port, ready already dropped
        checks += 2;
        if (bus.in_ready !== 1'b0) begin $display("FAIL basic_flush_ready: got %b, required 0", bus.in_ready); errors++; end
        if (bus.wr_en !== 1'b1)    begin $display("FAIL basic_flush_wr_en: got %b, required 1", bus.wr_en); errors++; end
        repeat (4) step();
        checks += 4;
        if (log_n !== 8)              begin $display("FAIL basic_count: got %0d writes, required 8", log_n); errors++; end
        if (done_n !== 1)             begin $display("FAIL basic_done_n: got %0d, required 1", done_n); errors++; end
        if (done_cyc !== last_acc + 2) begin $display("FAIL basic_done_time: got cycle %0d, required %0d", done_cyc, last_acc + 2); errors++; end
        if (bus.wr_bank !== 1'b1)     begin $display("FAIL basic_bank_after: got %b, required 1", bus.wr_bank); errors++; end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== 16'(i) || log_bank[i] !== 1'b0) begin
                $display("FAIL basic_write[%0d]: got (%0d,%0h,b%b), required (%0d,%0h,b0)",
                         i, log_addr[i], log_data[i], log_bank[i], exp_addr[i], i);
                errors++;
            end
        end
    endtask

    task automatic test_gaps();
        clear_log();
        pulse_start();
        drive_frame(16'h0100, 8'b0010_0100, -1, 8);
        repeat (4) step();
        checks += 3;
        if (log_n !== 8)          begin $display("FAIL gaps_count: got %0d writes, required 8", log_n); errors++; end
        if (done_n !== 1)         begin $display("FAIL gaps_done_n: got %0d, required 1", done_n); errors++; end
        if (bus.wr_bank !== 1'b0) begin $display("FAIL gaps_bank_after: got %b, required 0", bus.wr_bank); errors++; end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== 16'h0100 + 16'(i) || log_bank[i] !== 1'b1) begin
                $display("FAIL gaps_write[%0d]: got (%0d,%0h,b%b), required (%0d,%0h,b1)",
                         i, log_addr[i], log_data[i], log_bank[i], exp_addr[i], 16'h0100 + 16'(i));
                errors++;
            end
        end
        for (int i = 1; i < 8; i++) begin
            int want;
            want = (i == 2 || i == 5) ? 4 : 1;
            checks++;
            if (log_cyc[i] - log_cyc[i-1] !== want) begin
                $display("FAIL gaps_spacing[%0d]: got %0d cycles, required %0d", i, log_cyc[i] - log_cyc[i-1], want);
                errors++;
            end
        end
    endtask

    task automatic test_start_ignored();
        clear_log();
        pulse_start();
        drive_frame(16'h0200, 8'h00, 4, 8);
        repeat (4) step();
        checks += 4;
        if (log_n !== 8)               begin $display("FAIL restart_count: got %0d writes, required 8", log_n); errors++; end
        if (done_n !== 1)              begin $display("FAIL restart_done_n: got %0d, required 1", done_n); errors++; end
        if (done_cyc !== last_acc + 2) begin $display("FAIL restart_done_time: got cycle %0d, required %0d", done_cyc, last_acc + 2); errors++; end
        if (bus.wr_bank !== 1'b1)      begin $display("FAIL restart_bank_after: got %b, required 1", bus.wr_bank); errors++; end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== 16'h0200 + 16'(i) || log_bank[i] !== 1'b0) begin
                $display("FAIL restart_write[%0d]: got (%0d,%0h,b%b), required (%0d,%0h,b0)",
                         i, log_addr[i], log_data[i], log_bank[i], exp_addr[i], 16'h0200 + 16'(i));
                errors++;
            end
        end
    endtask

    task automatic test_reset_abort();
        clear_log();
        pulse_start();
        drive_frame(16'h0aa0, 8'h00, -1, 3);
        step();
        rst = 1'b1;
        repeat (2) step();
        checks += 3;
        if (bus.wr_bank !== 1'b0) begin $display("FAIL abort_bank: got %b, required 0", bus.wr_bank); errors++; end
        if (bus.wr_en !== 1'b0)   begin $display("FAIL abort_wr_en: got %b, required 0", bus.wr_en); errors++; end
        if (bus.busy !== 1'b0)    begin $display("FAIL abort_busy: got %b, required 0", bus.busy); errors++; end
        rst = 1'b0;
        repeat (3) step();
        checks += 2;
        if (done_n !== 0) begin $display("FAIL abort_done: got %0d pulses, required 0", done_n); errors++; end
        if (log_n !== 3)  begin $display("FAIL abort_writes: got %0d writes, required 3", log_n); errors++; end
        clear_log();
        pulse_start();
        drive_frame(16'h0300, 8'h00, -1, 8);
        repeat (4) step();
        checks += 2;
        if (log_n !== 8)  begin $display("FAIL abort_new_count: got %0d writes, required 8", log_n); errors++; end
        if (done_n !== 1) begin $display("FAIL abort_new_done: got %0d, required 1", done_n); errors++; end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== 16'h0300 + 16'(i) || log_bank[i] !== 1'b0) begin
                $display("FAIL abort_new_write[%0d]: got (%0d,%0h,b%b), required (%0d,%0h,b0)",
                         i, log_addr[i], log_data[i], log_bank[i], exp_addr[i], 16'h0300 + 16'(i));
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int restart_at;
        int want_gap;
`ifdef SAMPLE_LOADER_AUTO_RESTART_EN
        restart_at = -1;
        want_gap   = 2;
`else
        restart_at = 0;
        want_gap   = 3;
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        clear_log();
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            drive_frame(16'h0400 + 16'(f * 16), 8'h00, (f == 0) ? -1 : restart_at, 8);
            if (f < 2) begin
                step();
                checks++;
                if (bus.done !== 1'b1) begin $display("FAIL b2b_done_frame%0d: got %b, required 1", f, bus.done); errors++; end
            end
        end
        repeat (4) step();
        checks += 3;
        if (log_n !== 24)         begin $display("FAIL b2b_count: got %0d writes, required 24", log_n); errors++; end
        if (done_n !== 3)         begin $display("FAIL b2b_done_n: got %0d, required 3", done_n); errors++; end
        if (bus.wr_bank !== 1'b1) begin $display("FAIL b2b_bank_after: got %b, required 1", bus.wr_bank); errors++; end
        for (int i = 0; i < 24; i++) begin
            logic        eb;
            logic [15:0] ed;
            eb = ((i / 8) == 1);
            ed = 16'h0400 + 16'((i / 8) * 16) + 16'(i % 8);
            checks++;
            if (log_addr[i] !== exp_addr[i % 8] || log_data[i] !== ed || log_bank[i] !== eb) begin
                $display("FAIL b2b_write[%0d]: got (%0d,%0h,b%b), required (%0d,%0h,b%b)",
                         i, log_addr[i], log_data[i], log_bank[i], exp_addr[i % 8], ed, eb);
                errors++;
            end
        end
        checks++;
        if (log_cyc[8] - log_cyc[7] !== want_gap) begin
            $display("FAIL b2b_bubble: got %0d cycles, required %0d", log_cyc[8] - log_cyc[7], want_gap);
            errors++;
        end
    endtask

    initial begin
        exp_addr[0] = 3'd0; exp_addr[1] = 3'd4; exp_addr[2] = 3'd2; exp_addr[3] = 3'd6;
        exp_addr[4] = 3'd1; exp_addr[5] = 3'd5; exp_addr[6] = 3'd3; exp_addr[7] = 3'd7;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        test_reset();
        test_basic();
        test_gaps();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter N, default 8: transform length; power of two, N >= 2.
REQ-002 Parameter BITS_PER_ROW, default 3: log2(N), the address width.
REQ-003 Parameter DATA_W, default 16: sample width.
REQ-004 clk  input  1  the only clock; every register updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to load one frame.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_data  input  DATA_W  sample, presented in natural order.
REQ-009 in_ready  output  1  loader accepts a sample this cycle.
REQ-010 wr_en  output  1  RAM write strobe.
REQ-011 wr_addr  output  BITS_PER_ROW  bit-reversed write address.
REQ-012 wr_data  output  DATA_W  write data.
REQ-013 wr_bank  output  1  ping-pong bank select for the frame being written.
REQ-014 busy  output  1  high while in LOAD.
REQ-015 done  output  1  one-cycle pulse when a frame is complete.

Function
REQ-016 FSM states: IDLE, LOAD, FLUSH; encoding free.
REQ-017 IDLE -> LOAD when start=1. Entry clears sample counter cnt (BITS_PER_ROW+1 bits).
REQ-018 in_ready = 1 exactly when state==LOAD and cnt<N; combinational from state/cnt only, never from in_valid.
REQ-019 A sample is accepted in any cycle with in_valid=1 and in_ready=1; cnt increments by 1 on accept.
REQ-020 Write port latency: on the cycle after an accept, wr_en=1 and wr_data is the accepted sample.
REQ-021 wr_addr = bit-reverse(cnt[BITS_PER_ROW-1:0]) at accept time: bit 0 maps to MSB, bit BITS_PER_ROW-1 to LSB.
REQ-022 wr_en=0 in all cycles not following an accept; in_valid gaps insert idle cycles without losing order.
REQ-023 When the N-th sample is accepted: LOAD -> FLUSH; in_ready drops in the next cycle.
REQ-024 FLUSH lasts exactly one cycle, holding the final write. Then done=1 for one cycle; wr_bank toggles in that same cycle; state -> IDLE.
REQ-025 wr_bank is constant throughout a frame's writes.
REQ-026 start while busy=1 or in FLUSH is ignored, with no effect on cnt or bank.
REQ-027 in_valid while in IDLE is ignored (in_ready=0).
REQ-028 start and done in the same cycle: start is honoured; the next frame writes to the toggled bank.

Reset
REQ-029 While rst=1: state=IDLE, cnt=0, wr_bank=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-030 rst mid-frame aborts the frame: no done pulse, no bank toggle, no further writes; the partial RAM contents are don't-care.
REQ-031 rst takes priority over start in the same cycle.

Configuration
REQ-032 Macro SAMPLE_LOADER_AUTO_RESTART_EN.
- Defined: leaving FLUSH goes straight to LOAD with cnt=0, on the toggled bank. Frames stream back-to-back with one bubble cycle. start only leaves IDLE after reset.
- Undefined: FLUSH -> IDLE as in REQ-024, and each frame needs a new start.
- All other requirements hold in both builds.

Verification (N=8, BITS_PER_ROW=3)
REQ-033 Reset, then start, then in_valid=1 continuously with data 0..7 -> write pairs (addr,data) = (0,0),(4,1),(2,2),(6,3),(1,4),(5,5),(3,6),(7,7), all with wr_bank=0; done pulses once, 2 cycles after the last accept; wr_bank becomes 1.
REQ-034 Same frame with in_valid deasserted on samples 2 and 5 for 3 cycles each -> identical addr/data sequence; wr_en low during the gaps; exactly one done.
REQ-035 start pulsed again at sample 4 of a frame, and in_valid asserted while in IDLE -> no change to the sequence or cnt; no write before start.
REQ-036 rst asserted after sample 3, then a new full frame -> no done for the aborted frame; new frame writes on wr_bank=0 with addresses starting at 0,4,2.
REQ-037 Two frames back-to-back (start coincident with done) -> frame 2 on wr_bank=1, frame 3 on wr_bank=0. With SAMPLE_LOADER_AUTO_RESTART_EN defined, frame 2 loads without a second start.
